// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 9-bit-PC simpleRISC core.
//
// Owns the architectural PC, fetches 16-bit instruction words over a req/ack
// handshake and holds the fetched word in an instruction register whose fields
// are presented to the PC-update and execute stages. The PC is reloaded from
// pc_next only when execute accepts the issued instruction.
//
// Optional feature: define FETCH_TIMEOUT_EN to bound the wait for imem_ack to
// TIMEOUT cycles; on expiry fetch_err is set (sticky) and the unit halts.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and address (address == pc)
//   imem_ack/imem_rdata   memory response; only looked at while requesting
//   pc                    address of the held / in-flight instruction
//   ir_valid              instruction register holds an instruction to issue
//   op/opcode/cond/im8    decoded IR fields (im8 sign-extended to 9 bits)
//   ex_ready              execute accepts the issued instruction
//   pc_next               next PC from the PC-update stage
//   halted                HALT retired (or fetch timed out); fetch stopped
//   fetch_err             fetch timeout seen (always 0 without the feature)

module fetch_unit #(
    parameter logic [8:0]  RESET_PC = 9'h000,
    parameter logic [1:0]  HALT_OP  = 2'b11,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [8:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [8:0]  pc,
    output logic        ir_valid,
    output logic [1:0]  op,
    output logic [2:0]  opcode,
    output logic [2:0]  cond,
    output logic [8:0]  im8,
    input  logic        ex_ready,
    input  logic [8:0]  pc_next,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [8:0]  pc_q, pc_d;
    logic        is_halt_instr;
    logic        timeout;

    assign is_halt_instr = (ir_q[15:14] == HALT_OP) && (ir_q[13:11] == 3'b111);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Counter holds the number of ack-less FETCH cycles already elapsed, so the
    // TIMEOUT-th cycle is the one where it equals TIMEOUT-1. An ack on that
    // cycle still wins because timeout is qualified with !imem_ack.
    assign timeout = (state_q == StFetch) && !imem_ack && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        if (state_q == StFetch && !imem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout        = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= 16'h0000;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StIssue;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StIssue: begin
                if (ex_ready) begin
                    if (is_halt_instr) begin
                        state_d = StHalt;
                    end else begin
                        pc_d    = pc_next;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StFetch: imem_req = 1'b1;
            StIssue: ir_valid = 1'b1;
            StHalt:  halted   = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign op        = ir_q[15:14];
    assign opcode    = ir_q[13:11];
    assign cond      = ir_q[10:8];
    assign im8       = {ir_q[7], ir_q[7:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of fetch/issue vectors replayed
// through the req/ack and ex_ready handshakes, followed by hand-written
// sequences for HALT, asynchronous reset and the fetch-wait limit.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [8:0]  pc;
    logic        ir_valid;
    logic [1:0]  op;
    logic [2:0]  opcode;
    logic [2:0]  cond;
    logic [8:0]  im8;
    logic        ex_ready = 1'b0;
    logic [8:0]  pc_next = 9'h000;
    logic        halted;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .ir_valid   (ir_valid),
        .op         (op),
        .opcode     (opcode),
        .cond       (cond),
        .im8        (im8),
        .ex_ready   (ex_ready),
        .pc_next    (pc_next),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        int          req_cycles;  // cycles imem_req is high, ack on the last
        int          stall;       // ISSUE cycles with ex_ready low
        logic [8:0]  pc_next;
        logic [1:0]  op;
        logic [2:0]  opcode;
        logic [2:0]  cond;
        logic [8:0]  im8;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"},  16'(imem_req),  16'h0);
        check({tag, " ir_valid"},  16'(ir_valid),  16'h0);
        check({tag, " halted"},    16'(halted),    16'h0);
        check({tag, " fetch_err"}, 16'(fetch_err), 16'h0);
        check({tag, " pc"},        16'(pc),        16'h000);
        check({tag, " fields"},    {2'b00, op, opcode, cond, im8[5:0]}, 16'h0);
        check({tag, " im8"},       16'(im8),       16'h000);
    endtask

    task automatic check_issue(input string tag, input vec_t v, input logic [8:0] exp_pc);
        check({tag, " ir_valid"}, 16'(ir_valid), 16'h1);
        check({tag, " imem_req"}, 16'(imem_req), 16'h0);
        check({tag, " op"},       16'(op),       16'(v.op));
        check({tag, " opcode"},   16'(opcode),   16'(v.opcode));
        check({tag, " cond"},     16'(cond),     16'(v.cond));
        check({tag, " im8"},      16'(im8),      16'(v.im8));
        check({tag, " pc"},       16'(pc),       16'(exp_pc));
    endtask

    // Wait in FETCH with ack low, then ack with rdata; counts req-high cycles.
    task automatic do_fetch(input string tag, input logic [15:0] rdata, input int req_cycles,
                            input logic [8:0] exp_pc);
        int seen = 0;
        for (int k = 0; k < req_cycles - 1; k++) begin
            if (imem_req) seen++;
            check({tag, " addr wait"}, 16'(imem_addr), 16'(exp_pc));
            imem_ack = 1'b0;
            tick();
        end
        if (imem_req) seen++;
        check({tag, " addr"}, 16'(imem_addr), 16'(exp_pc));
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        check({tag, " req cycles"}, 16'(seen), 16'(req_cycles));
    endtask

    logic [8:0] exp_pc;
    vec_t       hv;

    initial begin
        //             rdata     req stall pc_next  op     opcode  cond    im8
        vecs[0] = '{16'h0B03, 1, 3, 9'h006, 2'b00, 3'b001, 3'b011, 9'h003};
        vecs[1] = '{16'h00FD, 4, 1, 9'h1FF, 2'b00, 3'b000, 3'b000, 9'h1FD};
        vecs[2] = '{16'h6A80, 2, 0, 9'h000, 2'b01, 3'b101, 3'b010, 9'h180};
        vecs[3] = '{16'hB77F, 1, 2, 9'h0A5, 2'b10, 3'b110, 3'b111, 9'h07F};
        vecs[4] = '{16'hC700, 3, 0, 9'h033, 2'b11, 3'b000, 3'b111, 9'h000};
        vecs[5] = '{16'h3800, 1, 1, 9'h044, 2'b00, 3'b111, 3'b000, 9'h000};

        // Reset state, with ack toggling to show it is ignored.
        imem_ack = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        check("idle req", 16'(imem_req), 16'h0);
        tick();
        check("first req", 16'(imem_req), 16'h1);
        exp_pc = 9'h000;

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            do_fetch(tag, vecs[i].rdata, vecs[i].req_cycles, exp_pc);
            check_issue(tag, vecs[i], exp_pc);
            ex_ready = 1'b0;
            pc_next  = vecs[i].pc_next;
            for (int s = 0; s < vecs[i].stall; s++) begin
                imem_ack   = 1'b1;  // stray ack during ISSUE
                imem_rdata = 16'hFFFF;
                tick();
                check_issue({tag, " stall"}, vecs[i], exp_pc);
            end
            imem_ack = 1'b0;
            ex_ready = 1'b1;
            tick();
            ex_ready = 1'b0;
            pc_next  = 9'h155;
            exp_pc   = vecs[i].pc_next;
            check({tag, " next req"},  16'(imem_req),  16'h1);
            check({tag, " next addr"}, 16'(imem_addr), 16'(exp_pc));
            check({tag, " next irv"},  16'(ir_valid),  16'h0);
        end

        // HALT instruction.
        hv = '{16'hF800, 1, 0, 9'h1AB, 2'b11, 3'b111, 3'b000, 9'h000};
        do_fetch("halt", hv.rdata, 1, exp_pc);
        check_issue("halt", hv, exp_pc);
        tick();
        check_issue("halt hold", hv, exp_pc);
        pc_next  = 9'h1AB;
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check("halt halted",   16'(halted),   16'h1);
        check("halt req",      16'(imem_req), 16'h0);
        check("halt ir_valid", 16'(ir_valid), 16'h0);
        check("halt pc",       16'(pc),       16'(exp_pc));
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'b1;
            tick();
            check("halt stays", {14'h0, halted, imem_req}, 16'h2);
        end
        imem_ack = 1'b0;
        check("halt no err", 16'(fetch_err), 16'h0);

        // Asynchronous reset mid-HALT: outputs return to reset values at once.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async rst");
        tick();
        check_reset_outputs("rst held");
        rst_n = 1'b1;
        tick();

`ifdef FETCH_TIMEOUT_EN
        // Never ack: 14 FETCH cycles are fine, the 15th expires.
        for (int k = 0; k < 14; k++) begin
            tick();
        end
        check("to pre req",   16'(imem_req),  16'h1);
        check("to pre err",   16'(fetch_err), 16'h0);
        check("to pre halt",  16'(halted),    16'h0);
        tick();
        check("to err",    16'(fetch_err), 16'h1);
        check("to halted", 16'(halted),    16'h1);
        check("to req",    16'(imem_req),  16'h0);
        tick();
        tick();
        check("to err sticky", 16'(fetch_err), 16'h1);

        // Ack on the 15th cycle is captured normally.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        do_fetch("to ack", 16'h0B03, 15, 9'h000);
        check_issue("to ack", vecs[0], 9'h000);
        check("to ack err",  16'(fetch_err), 16'h0);
        check("to ack halt", 16'(halted),    16'h0);
`else
        // Without the limit, FETCH waits indefinitely and never flags an error.
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check("wait req",    16'(imem_req),  16'h1);
        check("wait err",    16'(fetch_err), 16'h0);
        check("wait halted", 16'(halted),    16'h0);
        do_fetch("late ack", 16'h0B03, 1, 9'h000);
        check_issue("late ack", vecs[0], 9'h000);
        check("late ack err", 16'(fetch_err), 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 9-bit-PC simpleRISC core. It owns the architectural program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. It presents decoded fields (op, opcode, cond, im8) to the branch/PC-update stage and to execute. The next PC computed downstream is loaded back only when execute accepts the issued instruction.

## Interface
- RESET_PC, 9'h000, PC value loaded on reset.
- HALT_OP, 2'b11, op field value that, together with opcode 3'b111, marks HALT.
- TIMEOUT, 15, max cycles to wait for imem_ack (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  9  fetch address; equals pc.
- imem_ack  in  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  in  16  instruction word; valid when imem_ack=1.
- pc  out  9  address of the instruction currently held or being fetched.
- ir_valid  out  1  instruction register holds an instruction for issue.
- op  out  2  ir[15:14].
- opcode  out  3  ir[13:11].
- cond  out  3  ir[10:8].
- im8  out  9  ir[7:0] sign-extended to 9 bits.
- ex_ready  in  1  execute accepts the issued instruction.
- pc_next  in  9  next PC from the PC-update stage, valid while ir_valid=1.
- halted  out  1  HALT retired; fetch stopped.
- fetch_err  out  1  timeout occurred (always 0 without FETCH_TIMEOUT_EN).

## Operation
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset. Moves to FETCH on the next edge unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - On an edge with imem_ack=1: ir<=imem_rdata, then go to ISSUE.
  - Otherwise stay in FETCH with pc unchanged.
- ISSUE: ir_valid=1; fields are driven from ir.
  - On an edge with ex_ready=1:
    - If op==HALT_OP and opcode==3'b111: go to HALT. pc is not updated.
    - Otherwise pc<=pc_next, then go to FETCH.
  - ex_ready=0: hold. ir, pc and the fields stay stable.
- HALT: halted=1; imem_req=0, ir_valid=0. Exits only via reset.
- Arithmetic: there is none in this block. pc_next is taken as given, so the 9-bit wrap (9'h1FF -> 9'h000) comes from upstream. im8 = {ir[7], ir[7:0]}.
- imem_ack outside FETCH is ignored.
- Reset mid-operation: any state returns to IDLE immediately. Any in-flight ack is dropped.

## Timing
- Reset values:
  - State: IDLE.
  - pc=RESET_PC; ir=16'h0000, so op, opcode, cond and im8 read 0.
  - imem_req=0, ir_valid=0, halted=0, fetch_err=0.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Minimum throughput: 2 cycles per instruction.
  - Cycle N: FETCH with ack=1.
  - Cycle N+1: ISSUE with ex_ready=1.
  - Cycle N+2: FETCH of pc_next.
- First imem_req appears in the second cycle after rst_n deasserts.
- imem_req and imem_addr stay stable until ack.
- ir_valid and the fields stay stable until the accepting edge.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without ack.
  - When the counter reaches TIMEOUT with no ack, fetch_err is set (sticky until reset) and the FSM goes to HALT. halted=1.
  - An ack arriving on the TIMEOUT-th cycle itself wins: the instruction is captured normally.
- FETCH_TIMEOUT_EN undefined:
  - No counter. FETCH waits indefinitely.
  - fetch_err is tied to 0.

## Test plan
- Reset with RESET_PC=0, then ack in the same cycle as req with rdata=16'h0B03 (op=00, opcode=001, cond=011, im8=03). Required: ir_valid next cycle, opcode=3'b001, cond=3'b011, im8=9'h003, pc=0.
- ISSUE with pc_next=9'h006 and ex_ready held low 3 cycles, then high. Required: fields stable for 3 cycles; the next FETCH has imem_addr=9'h006.
- rdata=16'h00FD. Required: im8=9'h1FD (sign extension).
- Memory ack delayed 4 cycles. Required: imem_req high for exactly 4 cycles; stray ack pulses during ISSUE are ignored.
- rdata=16'hF800 (op=11, opcode=111) accepted. Required: halted=1 next cycle, no further imem_req, pc unchanged. Then assert rst_n low mid-HALT. Required: all outputs return to reset values.
- With FETCH_TIMEOUT_EN and TIMEOUT=15: never ack. Required: fetch_err=1 and halted=1 after 15 FETCH cycles. Separately, ack on cycle 15. Required: normal capture and fetch_err=0.
